// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST controller: FSM state
// encoding, LFSR feedback taps, MISR polynomial and default run settings.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_t;

  // Fibonacci feedback taps of the 32-bit pattern LFSR: bits 31, 21, 1, 0.
  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
  // CRC-16-CCITT style feedback for the signature register.
  localparam logic [15:0] MISR_POLY      = 16'h1021;
  localparam logic [31:0] DEF_LFSR_SEED  = 32'h0000_0001;
  localparam logic [15:0] DEF_GOLDEN_SIG = 16'h0000;

  // One shift-left step of the pattern LFSR; feedback enters at bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/adder_bist_ctrl_if.sv
// Datapath port bundle between the BIST controller and the adder under test
// plus its response compactor. master = controller, slave = datapath.
interface adder_bist_ctrl_if #(
  parameter int N  = 16,
  parameter int CW = 6
);
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          ci;
  logic [CW-1:0] com_res;

  modport master (output a, output b, output ci, input com_res);
  modport slave  (input a, input b, input ci, output com_res);
endinterface

// File: rtl/adder_bist_misr.sv
// Purpose: 16-bit multiple-input signature register folding compactor output.
// Latency: absorbs dat on the same edge en is high; result visible next cycle.
// Backpressure: none; clr has priority over en, rst over both.
module adder_bist_misr
  import adder_bist_pkg::*;
#(
  parameter int CW    = 6,
  parameter int SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CW-1:0]    dat,
  output logic [SIG_W-1:0] misr
);

  // Shift with polynomial feedback and xor in the zero-extended compactor word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      misr <= '0;
    end else if (en) begin
      misr <= {misr[SIG_W-2:0], 1'b0}
            ^ (misr[SIG_W-1] ? SIG_W'(MISR_POLY) : '0)
            ^ SIG_W'(dat);
    end
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// Top of the adder BIST controller: FSM, pattern LFSR, pattern counter.
// Optional macro ADDER_BIST_CI_EN: when defined, carry-in is driven from the
// LFSR during a run; otherwise ci is tied to 0 and no carry-in logic exists.
//
// Purpose: drive LFSR patterns onto the adder, compact responses, grade result.
// Latency: start edge to done=1 is PAT_CNT+2 edges; busy for PAT_CNT+1 cycles.
// Backpressure: none; start is ignored while busy, rst aborts immediately.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int               N          = 16,
  parameter int               CW         = 6,
  parameter int               SIG_W      = 16,
  parameter int               PAT_CNT    = 256,
  parameter logic [31:0]      LFSR_SEED  = DEF_LFSR_SEED,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(DEF_GOLDEN_SIG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  adder_bist_ctrl_if.master  dp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [SIG_W-1:0]   signature
);

  // Counter is one bit wider than needed so it never wraps inside a run.
  localparam int               CNT_W    = $clog2(PAT_CNT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAT_CNT - 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0]      SEED_EFF = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

  bist_state_t      state;
  logic [31:0]      lfsr;
  logic [CNT_W-1:0] cnt;
  logic [SIG_W-1:0] misr;
  logic             run;
  logic             start_acc;

  assign run       = (state == ST_RUN);
  assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Operands are only presented while patterns are being applied.
  assign dp.a = run ? lfsr[31:16] : '0;
  assign dp.b = run ? lfsr[15:0]  : '0;
`ifdef ADDER_BIST_CI_EN
  assign dp.ci = run & (lfsr[31] ^ lfsr[0]);
`else
  assign dp.ci = 1'b0;
`endif

  // Compactor output is combinational on a/b/ci, so it is absorbed in the same cycle.
  adder_bist_misr #(
    .CW    (CW),
    .SIG_W (SIG_W)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (run),
    .dat  (dp.com_res),
    .misr (misr)
  );

  // Run sequencing with registered status outputs; a restart from DONE clears the old result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            lfsr      <= SEED_EFF;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
          end
        end
        ST_RUN: begin
          lfsr <= lfsr_step(lfsr);
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          signature <= misr;
          pass      <= (misr == GOLDEN_SIG);
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
